// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the DMA channel scheduler slice: default parameter
// values, the scheduler FSM state encoding and a small width helper.
// No ports (package).
// ---------------------------------------------------------------------------
package dma_pkg;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_LEN_W   = 6;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT     = 2'd2,
        ST_COMPLETE = 2'd3
    } dma_state_t;

    // Index width for a vector of n entries; a single channel still needs one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_rr_arbiter.sv
// ---------------------------------------------------------------------------
// dma_rr_arbiter
// Purely combinational round-robin picker. Searches the request vector from
// (i_lastGrant + 1) mod NUM_CH upward with wrap-around and returns the first
// requester found.
// Ports:
//   i_req       request vector, one bit per channel
//   i_lastGrant index of the most recently served channel
//   o_grant     one-hot grant (all zero when nothing requests)
//   o_index     binary index of the granted channel
//   o_anyValid  high when at least one request bit is set
// ---------------------------------------------------------------------------
module dma_rr_arbiter
    import dma_pkg::*;
#(
    parameter  int NUM_CH = DEF_NUM_CH,
    localparam int IDX_W  = idxWidth(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_lastGrant,
    output logic [NUM_CH-1:0] o_grant,
    output logic [IDX_W-1:0]  o_index,
    output logic              o_anyValid
);

    // Walk the channels in priority order starting just after the last
    // winner; the first requester seen takes the grant.
    always_comb begin : p_select
        int              cand;
        logic [IDX_W-1:0] candIdx;
        logic            found;
        o_grant    = '0;
        o_index    = '0;
        o_anyValid = 1'b0;
        found      = 1'b0;
        cand       = 0;
        candIdx    = '0;
        for (int off = 1; off <= NUM_CH; off++) begin
            cand    = (int'(i_lastGrant) + off) % NUM_CH;
            candIdx = IDX_W'(cand);
            if (!found && i_req[candIdx]) begin
                found            = 1'b1;
                o_anyValid       = 1'b1;
                o_index          = candIdx;
                o_grant[candIdx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_ch_scheduler.sv
// ---------------------------------------------------------------------------
// dma_ch_scheduler
// Shares one DMA engine among NUM_CH requesting channels. A round-robin
// arbiter picks a descriptor in IDLE, the scheduler latches it onto the
// engine outputs, pulses dma_trigger, waits (bounded by TIMEOUT) for
// dma_done and then reports completion or timeout on the owning channel.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid / req_ready         per-channel descriptor handshake
//   req_src / req_dest / req_len  packed per-channel descriptors
//   dma_trigger                   one-cycle start pulse to the engine
//   dma_src_addr / dma_dest_addr / dma_length  latched descriptor
//   dma_done                      engine completion
//   ch_done / ch_err              one-cycle completion / timeout pulses
//   busy                          high whenever not IDLE
//   grant_id                      channel owning the engine
// ---------------------------------------------------------------------------
module dma_ch_scheduler
    import dma_pkg::*;
#(
    parameter  int NUM_CH  = DEF_NUM_CH,
    parameter  int ADDR_W  = DEF_ADDR_W,
    parameter  int LEN_W   = DEF_LEN_W,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int IDX_W   = idxWidth(NUM_CH),
    localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH*ADDR_W-1:0] req_src,
    input  logic [NUM_CH*ADDR_W-1:0] req_dest,
    input  logic [NUM_CH*LEN_W-1:0]  req_len,
    output logic                     dma_trigger,
    output logic [ADDR_W-1:0]        dma_src_addr,
    output logic [ADDR_W-1:0]        dma_dest_addr,
    output logic [LEN_W-1:0]         dma_length,
    input  logic                     dma_done,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [NUM_CH-1:0]        ch_err,
    output logic                     busy,
    output logic [IDX_W-1:0]         grant_id
);

    dma_state_t        r_state;
    dma_state_t        w_nextState;
    logic [IDX_W-1:0]  r_grantId;
    logic [IDX_W-1:0]  r_lastGrant;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dest;
    logic [LEN_W-1:0]  r_len;
    logic              r_err;
    logic [CNT_W-1:0]  r_count;

    logic [NUM_CH-1:0] w_grant;
    logic [IDX_W-1:0]  w_grantIdx;
    logic              w_anyValid;
    logic              w_accept;
    logic              w_timeout;
    logic [ADDR_W-1:0] w_selSrc;
    logic [ADDR_W-1:0] w_selDest;
    logic [LEN_W-1:0]  w_selLen;
    logic [NUM_CH-1:0] w_idOneHot;

    dma_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arbiter (
        .i_req       (req_valid),
        .i_lastGrant (r_lastGrant),
        .o_grant     (w_grant),
        .o_index     (w_grantIdx),
        .o_anyValid  (w_anyValid)
    );

    assign w_selSrc   = req_src [int'(w_grantIdx) * ADDR_W +: ADDR_W];
    assign w_selDest  = req_dest[int'(w_grantIdx) * ADDR_W +: ADDR_W];
    assign w_selLen   = req_len [int'(w_grantIdx) * LEN_W  +: LEN_W];
    assign w_timeout  = (r_count == CNT_W'(TIMEOUT));
    assign w_idOneHot = NUM_CH'(1) << r_grantId;

    assign busy          = (r_state != ST_IDLE);
    assign grant_id      = r_grantId;
    assign dma_src_addr  = r_src;
    assign dma_dest_addr = r_dest;
    assign dma_length    = r_len;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and Moore/handshake outputs. A zero-length descriptor has
    // nothing for the engine to do, so it goes straight to COMPLETE. In WAIT
    // a dma_done arriving on the timeout cycle still counts as success.
    always_comb begin
        w_nextState = r_state;
        req_ready   = '0;
        dma_trigger = 1'b0;
        ch_done     = '0;
        ch_err      = '0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_anyValid) begin
                    req_ready   = w_grant;
                    w_accept    = 1'b1;
                    w_nextState = (w_selLen == '0) ? ST_COMPLETE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                dma_trigger = 1'b1;
                w_nextState = ST_WAIT;
            end
            ST_WAIT: begin
                if (dma_done || w_timeout) begin
                    w_nextState = ST_COMPLETE;
                end
            end
            ST_COMPLETE: begin
                if (r_err) begin
                    ch_err = w_idOneHot;
                end else begin
                    ch_done = w_idOneHot;
                end
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Descriptor capture, wait counter and completion bookkeeping. The
    // descriptor is only written on acceptance so the engine outputs stay
    // stable for the whole transfer. The counter saturates at TIMEOUT and
    // clears whenever the FSM is outside WAIT. last_grant starts at the top
    // channel so channel 0 is the first winner after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grantId   <= '0;
            r_lastGrant <= IDX_W'(NUM_CH - 1);
            r_src       <= '0;
            r_dest      <= '0;
            r_len       <= '0;
            r_err       <= 1'b0;
            r_count     <= '0;
        end else begin
            if (w_accept) begin
                r_src     <= w_selSrc;
                r_dest    <= w_selDest;
                r_len     <= w_selLen;
                r_grantId <= w_grantIdx;
                r_err     <= 1'b0;
            end
            if (r_state == ST_WAIT) begin
                if (!w_timeout) begin
                    r_count <= r_count + CNT_W'(1);
                end
                if (w_timeout && !dma_done) begin
                    r_err <= 1'b1;
                end
            end else begin
                r_count <= '0;
            end
            if (r_state == ST_COMPLETE) begin
                r_lastGrant <= r_grantId;
            end
        end
    end

endmodule

// File: tb/tb_dma_ch_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dma_ch_scheduler
// Self-checking bench for dma_ch_scheduler: a table of directed transactions,
// hand-written reset-in-WAIT and idle sequences, and a randomized phase
// checked against a transaction-level model of the scheduler.
// ---------------------------------------------------------------------------
module tb_dma_ch_scheduler;

    localparam int NCH  = 4;
    localparam int AW   = 32;
    localparam int LW   = 6;
    localparam int TOUT = 20;

    logic              clk;
    logic              rst;
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_ready;
    logic [NCH*AW-1:0] req_src;
    logic [NCH*AW-1:0] req_dest;
    logic [NCH*LW-1:0] req_len;
    logic              dma_trigger;
    logic [AW-1:0]     dma_src_addr;
    logic [AW-1:0]     dma_dest_addr;
    logic [LW-1:0]     dma_length;
    logic              dma_done;
    logic [NCH-1:0]    ch_done;
    logic [NCH-1:0]    ch_err;
    logic              busy;
    logic [1:0]        grant_id;

    dma_ch_scheduler #(
        .NUM_CH  (NCH),
        .ADDR_W  (AW),
        .LEN_W   (LW),
        .TIMEOUT (TOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_src       (req_src),
        .req_dest      (req_dest),
        .req_len       (req_len),
        .dma_trigger   (dma_trigger),
        .dma_src_addr  (dma_src_addr),
        .dma_dest_addr (dma_dest_addr),
        .dma_length    (dma_length),
        .dma_done      (dma_done),
        .ch_done       (ch_done),
        .ch_err        (ch_err),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester-side view of the pending descriptors.
    logic [NCH-1:0] tbValid;
    logic [AW-1:0]  tbSrc  [NCH];
    logic [AW-1:0]  tbDest [NCH];
    logic [LW-1:0]  tbLen  [NCH];
    int             mdlLastGrant;
    int             nChecks;
    int             nFails;

    typedef struct {
        bit          doReset;
        logic [3:0]  mask;
        logic [31:0] src;
        logic [31:0] dest;
        logic [5:0]  len;
        int          delay;
        bit          doneInIssue;
        bit          changeSrc;
        int          expGrant;
        int          expTrig;
        int          expKind;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [3:0] oneHot(input int c);
        logic [3:0] v;
        v = 4'b0001;
        return v << c;
    endfunction

    // Round-robin rule: the valid channel closest after the last winner.
    function automatic int rrPick(input logic [3:0] v, input int last);
        int best;
        int bestDist;
        int d;
        best     = -1;
        bestDist = 99;
        for (int c = 0; c < NCH; c++) begin
            if (v[c]) begin
                d = (c - last + 3) % NCH;
                if (d < bestDist) begin
                    bestDist = d;
                    best     = c;
                end
            end
        end
        return best;
    endfunction

    task automatic applyStimulus();
        req_valid = tbValid;
        for (int c = 0; c < NCH; c++) begin
            req_src [c*AW +: AW] = tbSrc[c];
            req_dest[c*AW +: AW] = tbDest[c];
            req_len [c*LW +: LW] = tbLen[c];
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_trig"}, dma_trigger, 0);
        checkOutput({tag, "_done"}, ch_done, 0);
        checkOutput({tag, "_err"}, ch_err, 0);
        checkOutput({tag, "_gid"}, grant_id, 0);
        checkOutput({tag, "_src"}, dma_src_addr, 0);
        checkOutput({tag, "_dest"}, dma_dest_addr, 0);
        checkOutput({tag, "_len"}, dma_length, 0);
        checkOutput({tag, "_ready"}, req_ready, 0);
    endtask

    task automatic doResetSeq();
        rst     = 1'b1;
        tbValid = '0;
        dma_done = 1'b0;
        applyStimulus();
        @(negedge clk);
        checkAllZero("rst");
        stepCycle();
        rst = 1'b0;
        mdlLastGrant = NCH - 1;
    endtask

    // One complete transaction from IDLE back to IDLE. The expected timeline
    // comes from the model: accept, trigger next cycle, WAIT counted from 0,
    // completion pulse one cycle after dma_done or after TIMEOUT+1 WAIT cycles.
    task automatic runTxn(input int doneDelay, input bit doneInIssue, input bit changeSrc,
                          output int gotGrant, output int gotTrig, output int gotKind);
        int         w;
        logic [31:0] accSrc;
        logic [31:0] accDest;
        logic [5:0]  accLen;
        bit          expErr;
        gotGrant = -1;
        gotTrig  = 0;
        gotKind  = 2;
        w = rrPick(tbValid, mdlLastGrant);
        if (w < 0) return;
        dma_done = 1'b0;
        applyStimulus();
        @(negedge clk);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_ready", req_ready, oneHot(w));
        accSrc  = tbSrc[w];
        accDest = tbDest[w];
        accLen  = tbLen[w];
        stepCycle();
        tbValid[w] = 1'b0;
        applyStimulus();
        if (accLen == 0) begin
            @(negedge clk);
            checkOutput("zl_trig", dma_trigger, 0);
            checkOutput("zl_done", ch_done, oneHot(w));
            checkOutput("zl_err", ch_err, 0);
            checkOutput("zl_busy", busy, 1);
            gotGrant = int'(grant_id);
            gotTrig += int'(dma_trigger);
            gotKind  = (ch_err != 0) ? 1 : ((ch_done != 0) ? 0 : 2);
            stepCycle();
        end else begin
            dma_done = doneInIssue;
            @(negedge clk);
            checkOutput("iss_trig", dma_trigger, 1);
            checkOutput("iss_gid", grant_id, w);
            checkOutput("iss_src", dma_src_addr, accSrc);
            checkOutput("iss_dest", dma_dest_addr, accDest);
            checkOutput("iss_len", dma_length, accLen);
            checkOutput("iss_ready", req_ready, 0);
            checkOutput("iss_done", ch_done | ch_err, 0);
            gotTrig += int'(dma_trigger);
            stepCycle();
            for (int k = 0; k <= TOUT; k++) begin
                dma_done = (k == doneDelay);
                if (changeSrc) begin
                    tbSrc[w] = ~tbSrc[w];
                    applyStimulus();
                end
                @(negedge clk);
                checkOutput("wait_trig", dma_trigger, 0);
                checkOutput("wait_pulse", ch_done | ch_err, 0);
                checkOutput("wait_ready", req_ready, 0);
                checkOutput("wait_busy", busy, 1);
                checkOutput("wait_src", dma_src_addr, accSrc);
                gotTrig += int'(dma_trigger);
                stepCycle();
                if (k == doneDelay) break;
            end
            dma_done = 1'b0;
            expErr = !(doneDelay >= 0 && doneDelay <= TOUT);
            @(negedge clk);
            checkOutput("cpl_done", ch_done, expErr ? 4'b0000 : oneHot(w));
            checkOutput("cpl_err", ch_err, expErr ? oneHot(w) : 4'b0000);
            checkOutput("cpl_trig", dma_trigger, 0);
            checkOutput("cpl_busy", busy, 1);
            checkOutput("cpl_src", dma_src_addr, accSrc);
            checkOutput("cpl_dest", dma_dest_addr, accDest);
            checkOutput("cpl_len", dma_length, accLen);
            gotGrant = int'(grant_id);
            gotTrig += int'(dma_trigger);
            gotKind  = (ch_err != 0) ? 1 : ((ch_done != 0) ? 0 : 2);
            stepCycle();
        end
        mdlLastGrant = w;
    endtask

    initial begin : main
        int g;
        int t;
        int kd;
        logic [3:0] save;
        int delay;

        nChecks      = 0;
        nFails       = 0;
        mdlLastGrant = NCH - 1;
        rst          = 1'b1;
        dma_done     = 1'b0;
        tbValid      = '0;
        for (int c = 0; c < NCH; c++) begin
            tbSrc[c]  = '0;
            tbDest[c] = '0;
            tbLen[c]  = '0;
        end
        applyStimulus();

        // doReset, mask, src, dest, len, delay, doneInIssue, changeSrc, expGrant, expTrig, expKind
        vecs[0]  = '{1'b1, 4'b0001, 32'h3,      32'h3,      6'd6,  3,        1'b0, 1'b0, 0, 1, 0};
        vecs[1]  = '{1'b1, 4'b1111, 32'h100,    32'h200,    6'd4,  2,        1'b0, 1'b0, 0, 1, 0};
        vecs[2]  = '{1'b0, 4'b1111, 32'h110,    32'h210,    6'd4,  1,        1'b0, 1'b0, 1, 1, 0};
        vecs[3]  = '{1'b0, 4'b1111, 32'h120,    32'h220,    6'd4,  4,        1'b0, 1'b0, 2, 1, 0};
        vecs[4]  = '{1'b0, 4'b1111, 32'h130,    32'h230,    6'd4,  0,        1'b0, 1'b0, 3, 1, 0};
        vecs[5]  = '{1'b0, 4'b1111, 32'h140,    32'h240,    6'd4,  2,        1'b0, 1'b0, 0, 1, 0};
        vecs[6]  = '{1'b0, 4'b0100, 32'h500,    32'h600,    6'd0,  0,        1'b0, 1'b0, 2, 0, 0};
        vecs[7]  = '{1'b0, 4'b1010, 32'h700,    32'h800,    6'd9,  -1,       1'b0, 1'b0, 3, 1, 1};
        vecs[8]  = '{1'b0, 4'b1010, 32'h900,    32'hA00,    6'd9,  0,        1'b0, 1'b0, 1, 1, 0};
        vecs[9]  = '{1'b0, 4'b0011, 32'hB00,    32'hC00,    6'd63, TOUT,     1'b0, 1'b0, 0, 1, 0};
        vecs[10] = '{1'b0, 4'b0010, 32'hD00,    32'hE00,    6'd7,  5,        1'b1, 1'b1, 1, 1, 0};
        vecs[11] = '{1'b0, 4'b1001, 32'hF00,    32'h1000,   6'd1,  TOUT + 1, 1'b0, 1'b0, 3, 1, 1};

        // Directed transaction table.
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].doReset) doResetSeq();
            tbValid = vecs[i].mask;
            for (int c = 0; c < NCH; c++) begin
                tbSrc[c]  = vecs[i].src + 32'(c);
                tbDest[c] = vecs[i].dest + 32'(c << 8);
                tbLen[c]  = vecs[i].len;
            end
            runTxn(vecs[i].delay, vecs[i].doneInIssue, vecs[i].changeSrc, g, t, kd);
            checkOutput($sformatf("vec%0d_grant", i), g, vecs[i].expGrant);
            checkOutput($sformatf("vec%0d_trig", i), t, vecs[i].expTrig);
            checkOutput($sformatf("vec%0d_kind", i), kd, vecs[i].expKind);
        end

        // Nothing requesting: no ready, stays idle.
        tbValid = '0;
        applyStimulus();
        @(negedge clk);
        checkOutput("noreq_ready", req_ready, 0);
        checkOutput("noreq_busy", busy, 0);
        stepCycle();

        // Reset while waiting on ch2: everything clears at once, no pulse,
        // then channel 0 wins the next arbitration.
        tbValid  = 4'b0100;
        tbSrc[2] = 32'hCAFE_0000;
        tbDest[2] = 32'hBEEF_0000;
        tbLen[2] = 6'd5;
        applyStimulus();
        @(negedge clk);
        checkOutput("rw_ready", req_ready, 4'b0100);
        stepCycle();
        tbValid = '0;
        applyStimulus();
        stepCycle();
        stepCycle();
        stepCycle();
        #2;
        rst = 1'b1;
        #1;
        checkAllZero("rw_async");
        @(negedge clk);
        checkOutput("rw_nodone", ch_done | ch_err, 0);
        stepCycle();
        checkOutput("rw_nodone2", ch_done | ch_err, 0);
        rst = 1'b0;
        mdlLastGrant = NCH - 1;
        tbValid = 4'b0101;
        tbSrc[0] = 32'h1234;
        tbDest[0] = 32'h5678;
        tbLen[0] = 6'd2;
        runTxn(1, 1'b0, 1'b0, g, t, kd);
        checkOutput("rw_first_grant", g, 0);

        // Randomized traffic; pending descriptors persist until accepted.
        tbValid = '0;
        for (int n = 0; n < 40; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!tbValid[c] && ($urandom_range(0, 1) == 1)) begin
                    tbValid[c] = 1'b1;
                    tbSrc[c]   = $urandom;
                    tbDest[c]  = $urandom;
                    tbLen[c]   = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
                end
            end
            if (tbValid == 0) begin
                tbValid[0] = 1'b1;
                tbLen[0]   = 6'd3;
            end
            if ($urandom_range(0, 4) == 0) begin
                save    = tbValid;
                tbValid = '0;
                applyStimulus();
                @(negedge clk);
                checkOutput("gap_ready", req_ready, 0);
                checkOutput("gap_busy", busy, 0);
                stepCycle();
                tbValid = save;
            end
            case ($urandom_range(0, 9))
                0:       delay = -1;
                1:       delay = TOUT;
                default: delay = int'($urandom_range(0, 8));
            endcase
            runTxn(delay, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), g, t, kd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
